seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Time-multiplexed seven-segment driver sitting directly downstream of the debug unit: it captures the debug unit's 16-bit `result` word and shows it as hexadecimal on a common-anode display, one digit at a time. A programmable divider sets the scan rate, and optional leading-zero blanking keeps the display readable. All outputs are registered, so the board pins are glitch-free.

## Interface
Parameters:
- `DIGITS`, 4: number of hex digits scanned; the data width is 4*DIGITS.
- `SCAN_DIV`, 50000: clock cycles each digit stays lit; legal range ≥ 2.

Ports:
- `clk` input, 1 bit: the only clock; all logic is rising-edge.
- `rst` input, 1 bit: reset, synchronous and active-low; sampled on the `clk` rising edge.
- `data` input, 4*DIGITS bits: value to display, normally the debug unit's `result`.
- `load` input, 1 bit: capture enable; when high at an edge, `data` is copied into the shadow register.
- `zero_blank` input, 1 bit: 1 = suppress leading zeros.
- `an` output, DIGITS bits: digit enables, active-low; bit i drives digit i, and digit 0 is the least-significant nibble.
- `seg` output, 7 bits: segment drive, active-low; seg[0]=a through seg[6]=g.
- `scan_tick` output, 1 bit: one-cycle pulse on each digit advance.

## Operation
- Shadow register `shd`:
  - Loaded from `data` on any edge where `rst`=1 and `load`=1.
  - Otherwise it holds its value.
  - The display always shows `shd`, never `data` directly.
- Divider `cnt`:
  - Counts 0..SCAN_DIV-1.
  - When `cnt`=SCAN_DIV-1 it wraps to 0, digit index `idx` advances, and `idx` wraps from DIGITS-1 to 0.
- `scan_tick` is registered: it is 1 in the cycle after the edge where `cnt` wrapped, otherwise 0.
- Nibble select: `nib` = `shd`[4*idx+3 : 4*idx].
- Hex decode (active-low, g..a order as a hex byte):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking: digit i is blank when all of the following hold:
  - `zero_blank`=1;
  - i≠0;
  - nibbles i..DIGITS-1 of `shd` are all zero.
- A value of 0 therefore shows a single "0".
- Output registers, updated every edge with `rst`=1:
  - Blank digit: `an` = all ones, `seg` = 7F.
  - Otherwise: `an` = all ones except bit `idx`=0; `seg` = decode(`nib`).
- `an` and `seg` always change on the same edge, so there is never a partial-digit state.
- Reset (`rst`=0 at an edge) sets:
  - `shd`=0, `cnt`=0, `idx`=0;
  - `an`=all ones, `seg`=7F, `scan_tick`=0.
- Reset overrides `load`.
- Reset mid-scan abandons the current digit; after release, the scan restarts at digit 0 with a full SCAN_DIV slot.

## Timing
- Outputs reflect `shd`/`idx`/`zero_blank` with exactly one cycle of latency.
- `load` at edge k updates `shd` at k.
- The new value appears on `seg`/`an` at edge k+1, if its digit is active.
- First edge after reset release (edge 1): `an`=…1110, `seg`=40 (digit 0 showing "0").
- Each digit stays on `an` for exactly SCAN_DIV cycles.
- Full refresh period is DIGITS*SCAN_DIV cycles.
- `load` on the same edge as a digit advance: the new `idx` and new `shd` are both used for the decode at the next edge. No mixing occurs.
- `load` held high continuously: `shd` tracks `data` every cycle, and the display follows with one cycle of lag.
- `zero_blank` toggling takes effect at the next edge, with no scan disturbance.
- `cnt` is sized to ceil(log2(SCAN_DIV)) bits.
- `idx` is sized to ceil(log2(DIGITS)) bits, minimum 1 bit.
- For non-power-of-2 DIGITS, `idx` never reaches an out-of-range value.

## Test plan
All scenarios use DIGITS=4 and SCAN_DIV=4.
1. Reset then release, with `load`=0:
   - `an`=1111, `seg`=7F during reset.
   - 1 cycle after release: `an`=1110, `seg`=40.
   - `scan_tick` pulses every 4 cycles.
   - `an` cycles 1110→1101→1011→0111→1110, each held for 4 cycles.
2. `load`=1 for one cycle with `data`=16'h1A5F, `zero_blank`=0:
   - Digits 0..3 show `seg` = 0E, 12, 08, 79.
   - The value persists after `data` changes to 0 with `load`=0.
3. `zero_blank`=1 with `shd`=16'h0005:
   - Digit 0: `an`=1110, `seg`=12.
   - Digits 1–3: `an`=1111, `seg`=7F.
   - With `shd`=16'h0000: only digit 0 is lit, showing 40.
   - With `shd`=16'h0100: digits 0, 1, 2 show 40, 40, 79; digit 3 is blank.
4. `load` pulsed on the exact edge where `cnt` wraps, with new `data`=16'h000A while digit 0 is becoming active:
   - The next-edge `seg` is 08 (the new value), never the old nibble.
5. `rst` low for one edge while digit 2 is active, with `load` high and `data`=16'hFFFF:
   - `shd` clears to 0 (`load` is ignored).
   - After release: `an`=1110, `seg`=40.
   - The first `scan_tick` arrives 4 cycles later.
6. `load` held high while `data` increments every cycle:
   - `seg` for the active digit equals decode of the previous cycle's nibble, with a one-cycle lag, checked over 32 cycles.

Source files
------------

// File: rtl/seg_scan_display.sv
// Time-multiplexed hex seven-segment driver for a common-anode display.
// A shadow register holds the value on show; a divider paces the digit scan,
// and leading zeros can be blanked. an/seg/scan_tick are all registered.
module seg_scan_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  load,
    input  logic                  zero_blank,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  scan_tick
);

    localparam int DATA_W = 4 * DIGITS;
    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Active-low segment pattern, bit 0 = a .. bit 6 = g.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [DATA_W-1:0] shd;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;

    logic [3:0]        nib;
    logic              upper_nz;
    logic              blank;
    logic [DIGITS-1:0] an_sel;
    logic [DIGITS-1:0] an_nxt;
    logic [6:0]        seg_nxt;

    // Select the active nibble and decide whether it is a leading zero.
    always_comb begin
        nib      = 4'h0;
        upper_nz = 1'b0;
        an_sel   = '1;
        for (int j = 0; j < DIGITS; j++) begin
            if (IDX_W'(j) == idx) begin
                nib       = shd[4*j +: 4];
                an_sel[j] = 1'b0;
            end
            if ((j >= int'(idx)) && (shd[4*j +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end
        // Digit 0 is never blanked, so a zero value still shows one "0".
        blank   = zero_blank && (idx != '0) && !upper_nz;
        an_nxt  = blank ? '1 : an_sel;
        seg_nxt = blank ? 7'h7F : hex7(nib);
    end

    // Shadow capture plus scan divider and digit index; reset wins over load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shd       <= '0;
            cnt       <= '0;
            idx       <= '0;
            scan_tick <= 1'b0;
        end else begin
            if (load) begin
                shd <= data;
            end
            scan_tick <= (cnt == CNT_LAST);
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Output registers: an and seg move together so no partial digit is seen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            an  <= '1;
            seg <= 7'h7F;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display with DIGITS=4, SCAN_DIV=4.
// Stimulus pushes the expected output of each edge; a monitor pops and
// compares on the falling edge.
module tb_seg_scan_display;

    logic        clk;
    logic        rst;
    logic [15:0] data;
    logic        load;
    logic        zero_blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        scan_tick;

    seg_scan_display #(
        .DIGITS   (4),
        .SCAN_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .load       (load),
        .zero_blank (zero_blank),
        .an         (an),
        .seg        (seg),
        .scan_tick  (scan_tick)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       tick;
        string      name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   ph    = 0;   // edges since reset release

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are presented every cycle, checked away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (an !== e.an) begin
                    bad++;
                    $display("FAIL %s an got=%b want=%b t=%0t", e.name, an, e.an, $time);
                end
                total++;
                if (seg !== e.seg) begin
                    bad++;
                    $display("FAIL %s seg got=%h want=%h t=%0t", e.name, seg, e.seg, $time);
                end
                total++;
                if (scan_tick !== e.tick) begin
                    bad++;
                    $display("FAIL %s scan_tick got=%b want=%b t=%0t", e.name, scan_tick, e.tick, $time);
                end
            end
        end
    end

    task automatic edge_push(input exp_t e);
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    // Run n edges; per-digit segment values and lit mask are given by hand.
    task automatic scan(input int n, input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3,
                        input logic [3:0] lit, input string nm);
        logic [6:0] s [4];
        exp_t e;
        int d;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int i = 0; i < n; i++) begin
            ph++;
            d      = ((ph - 1) / 4) % 4;
            e.an   = lit[d] ? ~(4'b0001 << d) : 4'hF;
            e.seg  = lit[d] ? s[d] : 7'h7F;
            e.tick = (ph % 4 == 0);
            e.name = nm;
            edge_push(e);
        end
    endtask

    initial begin
        exp_t e;
        logic [15:0] prev;
        int d;
        rst = 1'b0; load = 1'b0; data = 16'h0; zero_blank = 1'b0;

        // 1: reset, release, plain scan of zero
        e.an = 4'hF; e.seg = 7'h7F; e.tick = 1'b0; e.name = "t1_reset";
        edge_push(e);
        edge_push(e);
        rst = 1'b1;
        ph  = 0;
        scan(17, 7'h40, 7'h40, 7'h40, 7'h40, 4'b1111, "t1_scan");

        // 2: single-cycle load of 1A5F, then data removed
        load = 1'b1; data = 16'h1A5F;
        scan(1, 7'h40, 7'h40, 7'h40, 7'h40, 4'b1111, "t2_pre");
        load = 1'b0; data = 16'h0;
        scan(18, 7'h0E, 7'h12, 7'h08, 7'h79, 4'b1111, "t2_1A5F");

        // 3: leading-zero blanking
        zero_blank = 1'b1; load = 1'b1; data = 16'h0005;
        scan(1, 7'h0E, 7'h12, 7'h08, 7'h79, 4'b1111, "t3_pre");
        load = 1'b0;
        scan(16, 7'h12, 7'h7F, 7'h7F, 7'h7F, 4'b0001, "t3_0005");
        load = 1'b1; data = 16'h0000;
        scan(1, 7'h12, 7'h7F, 7'h7F, 7'h7F, 4'b0001, "t3_0005b");
        load = 1'b0;
        scan(16, 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0001, "t3_0000");
        load = 1'b1; data = 16'h0100;
        scan(1, 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0001, "t3_0000b");
        load = 1'b0;
        scan(16, 7'h40, 7'h40, 7'h79, 7'h7F, 4'b0111, "t3_0100");

        // 4: load on the wrap edge into digit 0
        zero_blank = 1'b0;
        scan(8, 7'h40, 7'h40, 7'h79, 7'h40, 4'b1111, "t4_pre");
        load = 1'b1; data = 16'h000A;
        scan(1, 7'h40, 7'h40, 7'h79, 7'h40, 4'b1111, "t4_wrap");
        load = 1'b0; data = 16'h0;
        scan(10, 7'h08, 7'h40, 7'h40, 7'h40, 4'b1111, "t4_000A");

        // 5: reset pulse during digit 2 with load high
        rst = 1'b0; load = 1'b1; data = 16'hFFFF;
        e.an = 4'hF; e.seg = 7'h7F; e.tick = 1'b0; e.name = "t5_reset";
        edge_push(e);
        rst = 1'b1; load = 1'b0; data = 16'h0;
        ph  = 0;
        scan(8, 7'h40, 7'h40, 7'h40, 7'h40, 4'b1111, "t5_after");

        // 6: load held high, data incrementing; display lags by one cycle
        load = 1'b1; data = 16'h3FF8; prev = 16'h0000;
        for (int i = 0; i < 33; i++) begin
            ph++;
            d      = ((ph - 1) / 4) % 4;
            e.an   = ~(4'b0001 << d);
            e.seg  = tbl[prev[4*d +: 4]];
            e.tick = (ph % 4 == 0);
            e.name = "t6_track";
            edge_push(e);
            prev = data;
            data = data + 16'h1;
        end
        load = 1'b0;

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
